// File: rtl/tile_ctrl_gen.sv
// Tile-sequencing controller for an ARR x ARR MAC array: walks every (t,m,n) tile
// of an {M,N,T} job, issuing load strobes, buffer addresses, run and store control.
module tile_ctrl_gen #(
    parameter int ARR   = 4,
    parameter int DIM_W = 5,
    localparam int LG   = $clog2(ARR),
    localparam int TIW  = DIM_W - LG,
    localparam int AW   = 2 * TIW + LG
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               Start,
    input  logic               Abort,
    input  logic [3*DIM_W-1:0] MNT,
    input  logic               Tile_Done,
    input  logic               LOAD_DONE,
    input  logic               STORE_DONE,
    input  logic               INIT_DONE,
    output logic               LOAD_I,
    output logic               LOAD_W,
    output logic               START_CALC,
    output logic               ACC,
    output logic               OMSRC,
    output logic [LG-1:0]      ICOL,
    output logic [LG-1:0]      WROW,
    output logic [LG:0]        ROW_TOTAL,
    output logic [AW-1:0]      ADDR_I,
    output logic [AW-1:0]      ADDR_W,
    output logic [AW-1:0]      ODST,
    output logic [LG+2:0]      shamt,
    output logic               CLR_DP,
    output logic               CLR_W,
    output logic               BUSY,
    output logic               DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_BOTH, S_LOAD_INPUT, S_RUN, S_WAIT, S_STORE_ACC, S_BRANCH
    } state_t;

    state_t             state, state_nx;
    logic [DIM_W-1:0]   m_dim, n_dim, t_dim;
    logic [DIM_W-1:0]   mnt_m, mnt_n, mnt_t;
    logic [TIW-1:0]     t_idx, m_idx, n_idx;
    logic [LG:0]        i_cnt, w_cnt;
    logic [LG-1:0]      run_cnt;
    logic [TIW:0]       tot_m, tot_n, tot_t;
    logic [LG:0]        rem_m, rem_n, rem_t;
    logic [LG-1:0]      lack;
    logic               t_last, m_last, n_last, tile_last;
    logic               in_load_i, i_fin, w_fin;
    logic               start_ok, dims_zero;
    logic               done_z, abort_clr, omsrc_q;

    function automatic logic [TIW:0] tot_of(input logic [DIM_W-1:0] x);
        return (TIW+1)'(({1'b0, x} + (DIM_W+1)'(ARR - 1)) >> LG);
    endfunction

    // Rows left in tile idx, clamped to [0, ARR].
    function automatic logic [LG:0] rem_of(input logic [DIM_W-1:0] x, input logic [TIW-1:0] idx);
        logic [DIM_W-1:0] base, left;
        base = {idx, {LG{1'b0}}};
        left = (x > base) ? x - base : '0;
        return (left > DIM_W'(ARR)) ? (LG+1)'(ARR) : (LG+1)'(left);
    endfunction

    assign {mnt_m, mnt_n, mnt_t} = MNT;
    assign dims_zero = (mnt_m == '0) || (mnt_n == '0) || (mnt_t == '0);
    assign start_ok  = (state == S_IDLE) && Start && !Abort;

    assign tot_m = tot_of(m_dim);
    assign tot_n = tot_of(n_dim);
    assign tot_t = tot_of(t_dim);
    assign rem_m = rem_of(m_dim, m_idx);
    assign rem_n = rem_of(n_dim, n_idx);
    assign rem_t = rem_of(t_dim, t_idx);

    assign t_last    = ({1'b0, t_idx} == tot_t - (TIW+1)'(1));
    assign m_last    = ({1'b0, m_idx} == tot_m - (TIW+1)'(1));
    assign n_last    = ({1'b0, n_idx} == tot_n - (TIW+1)'(1));
    assign tile_last = t_last && m_last && n_last;

    assign in_load_i = (state == S_LOAD_BOTH) || (state == S_LOAD_INPUT);
    assign LOAD_I    = in_load_i && (i_cnt < rem_t);
    assign LOAD_W    = (state == S_LOAD_BOTH) && (w_cnt < rem_m);
    // Leave the load state in the same cycle as the final strobe so RUN follows it directly.
    assign i_fin     = (i_cnt + (LG+1)'(LOAD_I)) >= rem_t;
    assign w_fin     = (w_cnt + (LG+1)'(LOAD_W)) >= rem_m;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_nx = state;
        CLR_DP   = abort_clr;
        CLR_W    = abort_clr;
        DONE     = done_z;
        case (state)
            S_IDLE:       if (Start) state_nx = dims_zero ? S_IDLE : S_LOAD_BOTH;
            S_LOAD_BOTH:  if (i_fin && w_fin) state_nx = S_RUN;
            S_LOAD_INPUT: if (i_fin) state_nx = S_RUN;
            S_RUN:        if (run_cnt == LG'(ARR - 1)) state_nx = S_WAIT;
            S_WAIT: begin
                if (ACC) begin
                    if (LOAD_DONE) state_nx = S_STORE_ACC;
                end else if (Tile_Done) begin
                    state_nx = S_BRANCH;
                end
            end
            S_STORE_ACC:  if (STORE_DONE) state_nx = S_BRANCH;
            S_BRANCH: begin
                CLR_DP = 1'b1;
                if (tile_last) begin
                    state_nx = S_IDLE;
                    CLR_W    = 1'b1;
                    DONE     = !Abort;
                end else if (!t_last) begin
                    state_nx = S_LOAD_INPUT;
                end else begin
                    state_nx = S_LOAD_BOTH;
                    CLR_W    = 1'b1;
                end
            end
            default:      state_nx = S_IDLE;
        endcase
        if (Abort) state_nx = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_dim     <= '0;
            n_dim     <= '0;
            t_dim     <= '0;
            t_idx     <= '0;
            m_idx     <= '0;
            n_idx     <= '0;
            i_cnt     <= '0;
            w_cnt     <= '0;
            run_cnt   <= '0;
            done_z    <= 1'b0;
            abort_clr <= 1'b0;
            omsrc_q   <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            omsrc_q   <= !INIT_DONE || (state == S_STORE_ACC);
            abort_clr <= Abort;
            done_z    <= start_ok && dims_zero;
            if (start_ok) {m_dim, n_dim, t_dim} <= MNT;

            // Counters only survive while the next state keeps loading or running.
            if (state_nx != S_LOAD_BOTH && state_nx != S_LOAD_INPUT) i_cnt <= '0;
            else if (LOAD_I)                                         i_cnt <= i_cnt + (LG+1)'(1);
            if (state_nx != S_LOAD_BOTH) w_cnt <= '0;
            else if (LOAD_W)             w_cnt <= w_cnt + (LG+1)'(1);
            run_cnt <= (state == S_RUN && state_nx == S_RUN) ? run_cnt + LG'(1) : '0;

            if (Abort || (state == S_BRANCH && tile_last)) begin
                t_idx <= '0;
                m_idx <= '0;
                n_idx <= '0;
            end else if (state == S_BRANCH) begin
                if (!t_last) begin
                    t_idx <= t_idx + TIW'(1);
                end else begin
                    t_idx <= '0;
                    if (!m_last) begin
                        m_idx <= m_idx + TIW'(1);
                    end else begin
                        m_idx <= '0;
                        n_idx <= n_idx + TIW'(1);
                    end
                end
            end
        end
    end

    assign START_CALC = (state == S_RUN);
    assign ACC        = (n_idx != '0);
    assign BUSY       = (state != S_IDLE);
    assign OMSRC      = omsrc_q;
    assign ICOL       = i_cnt[LG-1:0];
    assign WROW       = w_cnt[LG-1:0];
    assign ROW_TOTAL  = rem_t;
    assign ADDR_I     = {n_idx, t_idx, i_cnt[LG-1:0]};
    assign ADDR_W     = {n_idx, m_idx, w_cnt[LG-1:0]};
    assign ODST       = {m_idx, t_idx, i_cnt[LG-1:0]};
    // Right-shift that aligns a partial last n tile; a full tile needs none.
    assign lack       = LG'((LG+1)'(ARR) - rem_n);
    assign shamt      = (rem_n == '0) ? '0 : {lack, 3'b000};

endmodule

// File: tb/tb_tile_ctrl_gen.sv
// Bench for tile_ctrl_gen: a tile-loop model predicts every output each cycle while
// handshakes, noise and job sizes are randomized.
module tb_tile_ctrl_gen;

    localparam int ARR   = 4;
    localparam int DIM_W = 5;
    localparam int LG    = 2;
    localparam int TIW   = DIM_W - LG;
    localparam int AW    = 2 * TIW + LG;

    typedef struct packed {
        logic          load_i, load_w, start_calc, acc, omsrc;
        logic [LG-1:0] icol, wrow;
        logic [LG:0]   row_total;
        logic [AW-1:0] addr_i, addr_w, odst;
        logic [LG+2:0] shamt;
        logic          clr_dp, clr_w, busy, done;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_n, start, abort, tile_done, load_done, store_done, init_done;
    logic [3*DIM_W-1:0] mnt;
    logic LOAD_I, LOAD_W, START_CALC, ACC, OMSRC, CLR_DP, CLR_W, BUSY, DONE;
    logic [LG-1:0] ICOL, WROW;
    logic [LG:0] ROW_TOTAL;
    logic [AW-1:0] ADDR_I, ADDR_W, ODST;
    logic [LG+2:0] shamt;

    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 0;
    bit   om_pend = 0;
    exp_t exp_q = '0;
    int   md_m = 0, md_n = 0, md_t = 0;

    always #5 CLK = ~CLK;

    tile_ctrl_gen #(.ARR(ARR), .DIM_W(DIM_W)) dut (
        .CLK(CLK), .RSTN(rst_n), .Start(start), .Abort(abort), .MNT(mnt),
        .Tile_Done(tile_done), .LOAD_DONE(load_done), .STORE_DONE(store_done),
        .INIT_DONE(init_done), .LOAD_I(LOAD_I), .LOAD_W(LOAD_W),
        .START_CALC(START_CALC), .ACC(ACC), .OMSRC(OMSRC), .ICOL(ICOL), .WROW(WROW),
        .ROW_TOTAL(ROW_TOTAL), .ADDR_I(ADDR_I), .ADDR_W(ADDR_W), .ODST(ODST),
        .shamt(shamt), .CLR_DP(CLR_DP), .CLR_W(CLR_W), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int tot(input int x);
        return (x + ARR - 1) / ARR;
    endfunction

    function automatic int rem(input int x, input int idx);
        int r;
        r = x - idx * ARR;
        if (r < 0) r = 0;
        if (r > ARR) r = ARR;
        return r;
    endfunction

    function automatic int shamt_of(input int x, input int idx);
        int r;
        r = rem(x, idx);
        return (r == 0) ? 0 : (ARR - r) * 8;
    endfunction

    // Expected outputs for tile (t,m,n) with given load counts; flags default low.
    function automatic exp_t build_exp(input int t, input int m, input int n, input int ic, input int wc);
        exp_t e;
        e           = '0;
        e.acc       = (n != 0);
        e.icol      = LG'(ic % ARR);
        e.wrow      = LG'(wc % ARR);
        e.row_total = (LG+1)'(rem(md_t, t));
        e.addr_i    = AW'(n * (1 << (TIW + LG)) + t * ARR + ic % ARR);
        e.addr_w    = AW'(n * (1 << (TIW + LG)) + m * ARR + wc % ARR);
        e.odst      = AW'(m * (1 << (TIW + LG)) + t * ARR + ic % ARR);
        e.shamt     = (LG+3)'(shamt_of(md_n, n));
        return e;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("LOAD_I",     64'(LOAD_I),     64'(exp_q.load_i));
            check("LOAD_W",     64'(LOAD_W),     64'(exp_q.load_w));
            check("START_CALC", 64'(START_CALC), 64'(exp_q.start_calc));
            check("ACC",        64'(ACC),        64'(exp_q.acc));
            check("OMSRC",      64'(OMSRC),      64'(exp_q.omsrc));
            check("ICOL",       64'(ICOL),       64'(exp_q.icol));
            check("WROW",       64'(WROW),       64'(exp_q.wrow));
            check("ROW_TOTAL",  64'(ROW_TOTAL),  64'(exp_q.row_total));
            check("ADDR_I",     64'(ADDR_I),     64'(exp_q.addr_i));
            check("ADDR_W",     64'(ADDR_W),     64'(exp_q.addr_w));
            check("ODST",       64'(ODST),       64'(exp_q.odst));
            check("shamt",      64'(shamt),      64'(exp_q.shamt));
            check("CLR_DP",     64'(CLR_DP),     64'(exp_q.clr_dp));
            check("CLR_W",      64'(CLR_W),      64'(exp_q.clr_w));
            check("BUSY",       64'(BUSY),       64'(exp_q.busy));
            check("DONE",       64'(DONE),       64'(exp_q.done));
        end
    end

    task automatic check_zero(input string name);
        check(name, 64'({LOAD_I, LOAD_W, START_CALC, ACC, OMSRC, ICOL, WROW, ROW_TOTAL,
                         ADDR_I, ADDR_W, ODST, shamt, CLR_DP, CLR_W, BUSY, DONE}), 64'(0));
    endtask

    // Randomize inputs the current phase must ignore; the rest are held low.
    task automatic set_noise(input bit td, input bit ld, input bit sd, input bit st);
        tile_done  = td ? 1'($urandom_range(0, 1)) : 1'b0;
        load_done  = ld ? 1'($urandom_range(0, 1)) : 1'b0;
        store_done = sd ? 1'($urandom_range(0, 1)) : 1'b0;
        start      = st ? 1'($urandom_range(0, 1)) : 1'b0;
        abort      = 1'b0;
        mnt        = (3*DIM_W)'($urandom);
        init_done  = ($urandom_range(0, 9) != 0);
    endtask

    task automatic cyc(input exp_t e, input bit store);
        e.omsrc = om_pend;
        exp_q   = e;
        @(posedge CLK);
        om_pend = !init_done || store;
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            set_noise(1, 1, 1, 0);
            cyc(build_exp(0, 0, 0, 0, 0), 0);
        end
    endtask

    task automatic mid_reset();
        chk_en = 0;
        #2 rst_n = 1'b0;
        #1 check_zero("mid_job_reset");
        @(posedge CLK);
        #1 rst_n = 1'b1;
        md_m = 0; md_n = 0; md_t = 0;
        om_pend = 0;
        chk_en = 1;
    endtask

    task automatic run_job(input int m_d, input int n_d, input int t_d,
                           input int abort_tile, input bit rst_load);
        exp_t e;
        int   tile_no, rt, rm, ld_len, d;
        bit   acc, last;
        set_noise(1, 1, 1, 0);
        start = 1'b1;
        mnt   = {DIM_W'(m_d), DIM_W'(n_d), DIM_W'(t_d)};
        cyc(build_exp(0, 0, 0, 0, 0), 0);
        md_m = m_d; md_n = n_d; md_t = t_d;
        if (m_d == 0 || n_d == 0 || t_d == 0) begin
            set_noise(1, 1, 1, 0);
            e = build_exp(0, 0, 0, 0, 0);
            e.done = 1'b1;
            cyc(e, 0);
            return;
        end
        tile_no = 0;
        for (int n = 0; n < tot(n_d); n++)
        for (int m = 0; m < tot(m_d); m++)
        for (int t = 0; t < tot(t_d); t++) begin
            rt = rem(t_d, t);
            rm = (t == 0) ? rem(m_d, m) : 0;
            ld_len = (rt > rm) ? rt : rm;
            for (int k = 0; k < ld_len; k++) begin
                set_noise(1, 1, 1, 1);
                if (rst_load && k == 2) begin
                    mid_reset();
                    return;
                end
                e = build_exp(t, m, n, (k < rt) ? k : rt, (k < rm) ? k : rm);
                e.load_i = (k < rt);
                e.load_w = (k < rm);
                e.busy   = 1'b1;
                cyc(e, 0);
            end
            for (int k = 0; k < ARR; k++) begin
                set_noise(1, 1, 1, 1);
                e = build_exp(t, m, n, 0, 0);
                e.start_calc = 1'b1;
                e.busy       = 1'b1;
                if (tile_no == abort_tile && k == 1) begin
                    abort = 1'b1;
                    cyc(e, 0);
                    set_noise(1, 1, 1, 0);
                    e = build_exp(0, 0, 0, 0, 0);
                    e.clr_dp = 1'b1;
                    e.clr_w  = 1'b1;
                    cyc(e, 0);
                    return;
                end
                cyc(e, 0);
            end
            acc = (n != 0);
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                set_noise(acc, !acc, 1, 1);
                if (k == d) begin
                    if (acc) load_done = 1'b1;
                    else     tile_done = 1'b1;
                end
                e = build_exp(t, m, n, 0, 0);
                e.busy = 1'b1;
                cyc(e, 0);
            end
            if (acc) begin
                d = $urandom_range(0, 3);
                for (int k = 0; k <= d; k++) begin
                    set_noise(1, 1, 0, 1);
                    if (k == d) store_done = 1'b1;
                    e = build_exp(t, m, n, 0, 0);
                    e.busy = 1'b1;
                    cyc(e, 1);
                end
            end
            last = (t == tot(t_d) - 1) && (m == tot(m_d) - 1) && (n == tot(n_d) - 1);
            set_noise(1, 1, 1, 1);
            e = build_exp(t, m, n, 0, 0);
            e.busy   = 1'b1;
            e.clr_dp = 1'b1;
            e.clr_w  = (t == tot(t_d) - 1);
            e.done   = last;
            cyc(e, 0);
            tile_no++;
        end
    endtask

    initial begin
        exp_t pin;
        int   rm, rn, rt, ab;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mnt = '0;
        tile_done = 1'b0; load_done = 1'b0; store_done = 1'b0; init_done = 1'b1;
        #3 check_zero("reset_state");

        check("pin_tot31", 64'(tot(31)), 64'(8));
        check("pin_rem9_t2", 64'(rem(9, 2)), 64'(1));
        check("pin_shamt_n6", 64'(shamt_of(6, 1)), 64'(16));
        md_m = 3; md_n = 6; md_t = 9;
        pin = build_exp(2, 0, 1, 0, 0);
        check("pin_final_addr_i", 64'(pin.addr_i), 64'(8'b001_010_00));
        md_m = 0; md_n = 0; md_t = 0;

        @(posedge CLK);
        #1 rst_n = 1'b1;
        chk_en = 1;
        idle(2);

        run_job(4, 4, 4, -1, 0);
        idle(2);
        run_job(3, 6, 9, -1, 0);
        idle(1);
        run_job(31, 31, 31, -1, 0);
        idle(1);
        run_job(5, 9, 7, 1, 0);
        idle(1);
        run_job(5, 9, 7, -1, 0);
        run_job(4, 0, 4, -1, 0);
        idle(2);
        run_job(4, 4, 4, -1, 1);
        idle(2);

        for (int j = 0; j < 8; j++) begin
            rm = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 17));
            rn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 17));
            rt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 17));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_job(rm, rn, rt, ab, 0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        chk_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tile_ctrl_gen.md
# tile_ctrl_gen

Parametrised tile-sequencing controller for the ARR×ARR MAC array. It latches problem dimensions {M,N,T} and walks every (t,m,n) tile in t-innermost, then m, then n order. For each tile it issues input/weight load strobes and buffer addresses, runs the array for ARR cycles, and hands results to the output path: plain store on the first n pass, accumulate-store (via WBuffer) on later passes. It succeeds the fixed 4×4/8-max controller with arbitrary tile counts, accumulation over any number of N tiles, abort, and BUSY/DONE status.

## Interface
- ARR, 4: array edge; power of 2, ≥2. LG = log2(ARR).
- DIM_W, 5: width of each dimension; dims 0..2^DIM_W−1. TIW = DIM_W−LG (tile-index width).
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- Start  in  1  begin job; honoured only in IDLE.
- Abort  in  1  synchronous job kill, any state.
- MNT  in  3*DIM_W  {M,N,T}, sampled when Start is accepted.
- Tile_Done  in  1  OutputStage finished storing the tile.
- LOAD_DONE  in  1  WBuffer has gathered the tile's rows.
- STORE_DONE  in  1  WBuffer finished the accumulate write.
- INIT_DONE  in  1  memory init finished.
- LOAD_I, LOAD_W  out  1  input / weight row load strobes.
- START_CALC  out  1  high exactly in RUN.
- ACC  out  1  current n tile index ≠ 0.
- OMSRC  out  1  registered; WBuffer owns memory bus.
- ICOL, WROW  out  LG  ICnt[LG-1:0], WCnt[LG-1:0].
- ROW_TOTAL  out  LG+1  rem_t.
- ADDR_I  out  2*TIW+LG  {n,t,ICnt[LG-1:0]}.
- ADDR_W  out  2*TIW+LG  {n,m,WCnt[LG-1:0]}.
- ODST  out  2*TIW+LG  {m,t,ICnt[LG-1:0]}.
- shamt  out  LG+3  (ARR−rem_n)*8; 0 when rem_n=0.
- CLR_DP, CLR_W  out  1  one-cycle datapath / weight clear.
- BUSY  out  1  state ≠ IDLE.
- DONE  out  1  one-cycle job-complete pulse.

## Operation
- Tile totals: tot_x = ceil(X/ARR) = (X+ARR−1)>>LG, computed in DIM_W+1 bits to avoid overflow. rem_x = min(ARR, X−idx*ARR), saturating at 0.
- Counters ICnt and WCnt (LG+1 bits) increment on their own strobe. ICnt clears outside LOAD_BOTH/LOAD_INPUT; WCnt clears outside LOAD_BOTH.
- LOAD_I = (LOAD_BOTH|LOAD_INPUT) & ICnt<rem_t. LOAD_W = LOAD_BOTH & WCnt<rem_m. Both are combinational.
- States:
  - IDLE: on Start, latch MNT. Any dim 0 → stay IDLE and pulse DONE next cycle. Else → LOAD_BOTH.
  - LOAD_BOTH: when both strobes are low → RUN.
  - LOAD_INPUT: when LOAD_I is low → RUN.
  - RUN: exactly ARR cycles (cnt LG bits), then → WAIT.
  - WAIT: if ACC, LOAD_DONE → STORE_ACC. Else Tile_Done → BRANCH.
  - STORE_ACC: on STORE_DONE → BRANCH.
  - BRANCH (one cycle): advance (t,m,n) with t wrapping into m, then n.
    - Last tile (t=tot_t−1, m=tot_m−1, n=tot_n−1): → IDLE, CLR_DP=CLR_W=1, DONE=1, indices reset to 0.
    - Next t ≠ 0: → LOAD_INPUT, CLR_DP=1.
    - Otherwise: → LOAD_BOTH, CLR_DP=CLR_W=1.
- OMSRC is registered from (~INIT_DONE | state==STORE_ACC).
- Abort has priority over every transition. Next cycle: IDLE, indices and counters 0, CLR_DP=CLR_W=1 for that cycle, no DONE.
- Start outside IDLE is ignored; MNT is not relatched.

## Timing
- Reset: state IDLE, M=N=T=0, indices 0, OMSRC 0. All outputs 0 (shamt 0 since rem_n=0).
- First LOAD strobe is in the cycle after Start is accepted.
- START_CALC rises the cycle after the last load strobe and stays high ARR cycles.
- WAIT samples Tile_Done/LOAD_DONE, and STORE_ACC samples STORE_DONE, in the same cycle. Input pulses ≥1 cycle; levels are acceptable.
- Tile_Done or STORE_DONE outside its consuming state has no effect.
- DONE and BRANCH clears appear in the BRANCH cycle. BUSY drops the cycle after.
- Reset asserted mid-job returns everything to reset values immediately.

## Test plan
- ARR=4, M=N=T=4 → LOAD_I/LOAD_W high 4 cycles together, START_CALC 4 cycles, Tile_Done → DONE with CLR_DP=CLR_W=1, ACC=0 throughout.
- M=3, N=6, T=9 → 6 tile passes. Per t pass: LOAD_I counts 4,4,1 and ROW_TOTAL 4,4,1; LOAD_W 3 only on t=0 passes. n=1 passes: ACC=1, shamt=16, path goes WAIT→STORE_ACC→BRANCH. ADDR_I on the final pass = {3'd1,3'd2,2'd0}.
- M=N=T=31 (max) → tot=8 each, 512 passes, final BRANCH gives DONE, no index overflow.
- Abort during RUN of the 2nd tile → next cycle IDLE with CLR_DP=CLR_W=1, DONE=0. New Start runs from tile (0,0,0).
- INIT_DONE=0 → OMSRC=1 one cycle later. INIT_DONE=1 → OMSRC follows STORE_ACC with 1-cycle lag.
- N=0 Start → DONE pulse, no LOAD strobes. Start asserted during WAIT is ignored. RSTN low in LOAD_BOTH → all outputs 0 immediately.
